// File: rtl/coin_credit_frontend.sv
// coin_credit_frontend: conditions coin/cancel lines, accumulates credit and drives sig_Coin/sig_Cancel.
// Credit is refunded on cancel, idle timeout or overpay; overflow is rejected, never truncated.
module coin_line_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic event_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level, level_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      level_q <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign event_pulse = level & ~level_q;
endmodule

module coin_credit_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRICE = 4,
  parameter int CREDIT_W = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                coin_raw,
  input  logic [1:0]          coin_denom,
  input  logic                cancel_raw,
  input  logic [3:0]          state_in,
  output logic                sig_Coin,
  output logic                sig_Cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                refund_pulse,
  output logic [CREDIT_W-1:0] refund_amount
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, VEND, REFUND} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, rem;
  logic [CREDIT_W:0] sum;
  logic [IW-1:0] idle, idle_n;
  logic coin_ev, accept;
  coin_line_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clock(clock), .reset_n(reset_n), .raw(coin_raw), .event_pulse(coin_ev));
  coin_line_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clock(clock), .reset_n(reset_n), .raw(cancel_raw), .event_pulse(sig_Cancel));
  // one extra bit so an overflowing coin is seen before it can wrap
  assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_denom);
  assign rem = credit - CREDIT_W'(PRICE);
  assign accept = coin_ev && coin_denom != 2'd0 && state_in == 4'd0 &&
                  (state == IDLE || state == ACCUM) &&
                  sum <= (CREDIT_W+1)'(2**CREDIT_W - 1);
  always_comb begin
    state_n = state;
    credit_n = credit;
    idle_n = '0;
    case (state)
      IDLE: if (accept) begin
        credit_n = sum[CREDIT_W-1:0];
        state_n = sum >= (CREDIT_W+1)'(PRICE) ? VEND : ACCUM;
      end
      ACCUM: begin
        credit_n = accept ? sum[CREDIT_W-1:0] : credit;
        idle_n = accept ? '0 : idle + 1'b1;
        state_n = (sig_Cancel || (!accept && idle == IW'(IDLE_TIMEOUT - 1))) ? REFUND :
                  (accept && sum >= (CREDIT_W+1)'(PRICE)) ? VEND : ACCUM;
      end
      VEND: if (state_in != 4'd0) begin
        credit_n = rem;
        state_n = rem != '0 ? REFUND : IDLE;
      end
      REFUND: begin
        credit_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      credit <= '0;
      idle <= '0;
      coin_reject <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      idle <= idle_n;
      coin_reject <= coin_ev & ~accept;
    end
  assign sig_Coin = state == VEND;
  assign refund_pulse = state == REFUND;
  assign refund_amount = refund_pulse ? credit : '0;
endmodule
